flash_read_arbiter: RTL

Shares the single read-only data port of the on-chip flash between two Avalon-MM read masters, for example the instruction fetch and the dump engine. Arbitration is round-robin with one transaction in flight at a time. A beat counter routes each `readdatavalid` back to the master that owns the current transaction. The block sits between the masters and the flash `avmm_data_*` port; the CSR port is not touched.

---
 rtl/flash_pkg.sv | 14 +
 rtl/flash_read_arbiter_if.sv | 26 ++
 rtl/rr_arb2.sv | 19 +
 rtl/flash_read_arbiter.sv | 119 +++++++++++
 4 files changed

// File: rtl/flash_pkg.sv
// Shared types and default widths for the flash data-port read arbiter.
package flash_pkg;

    localparam int FLASH_ADDR_W  = 17;
    localparam int FLASH_DATA_W  = 32;
    localparam int FLASH_BURST_W = 2;

    typedef enum logic [1:0] {
        FA_IDLE,
        FA_ISSUE,
        FA_DATA
    } fa_state_t;

endpackage

// File: rtl/flash_read_arbiter_if.sv
// One Avalon-MM read link: master drives the request, slave answers with
// waitrequest and the returned beats.
interface flash_read_arbiter_if
    import flash_pkg::*;
#(
    parameter int ADDR_W  = FLASH_ADDR_W,
    parameter int DATA_W  = FLASH_DATA_W,
    parameter int BURST_W = FLASH_BURST_W
);
    logic [ADDR_W-1:0]  addr;
    logic               read;
    logic [BURST_W-1:0] burstcount;
    logic               waitrequest;
    logic               readdatavalid;
    logic [DATA_W-1:0]  readdata;

    modport master (
        output addr, read, burstcount,
        input  waitrequest, readdatavalid, readdata
    );

    modport slave (
        input  addr, read, burstcount,
        output waitrequest, readdatavalid, readdata
    );
endinterface

// File: rtl/rr_arb2.sv
// Purpose: two-way round-robin pick; a lone requester wins, on a tie the one that was not served last wins.
// Latency: purely combinational.
// Backpressure: none; caller decides whether the pick is consumed.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    output logic       gnt_vld,
    output logic       gnt
);
    always_comb begin
        gnt_vld = |req;
        gnt     = 1'b0;
        if (req == 2'b11) begin
            gnt = ~last;
        end else begin
            gnt = req[1];
        end
    end
endmodule

// File: rtl/flash_read_arbiter.sv
// Purpose: shares the flash read data port between two Avalon-MM read masters, one transaction in flight.
// Latency: accept at T, flash_read at T+1; return beats are steered to the owner in the cycle they arrive.
// Backpressure: loser and busy-state requests see waitrequest high; flash waitrequest holds the ISSUE state.
module flash_read_arbiter
    import flash_pkg::*;
#(
    parameter int ADDR_W  = FLASH_ADDR_W,
    parameter int DATA_W  = FLASH_DATA_W,
    parameter int BURST_W = FLASH_BURST_W
) (
    input  logic                  clock,
    input  logic                  reset,
    flash_read_arbiter_if.slave   m0,
    flash_read_arbiter_if.slave   m1,
    flash_read_arbiter_if.master  flash
);
    localparam logic [BURST_W-1:0] ONE_REQ  = BURST_W'(1);
    localparam logic [BURST_W:0]   ONE_BEAT = (BURST_W+1)'(1);

    fa_state_t          state;
    fa_state_t          state_nxt;
    logic               grant;
    logic               last_grant;
    logic [ADDR_W-1:0]  addr_q;
    logic [BURST_W-1:0] burst_q;
    logic [BURST_W:0]   beats_left;

    logic               pick_vld;
    logic               pick;
    logic               accept;
    logic               last_beat;
    logic               beat_ok;
    logic [BURST_W-1:0] sel_burst;
    logic [DATA_W-1:0]  rd_dat;

    rr_arb2 u_rr_arb2 (
        .req     ({m1.read, m0.read}),
        .last    (last_grant),
        .gnt_vld (pick_vld),
        .gnt     (pick)
    );

    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        last_beat = 1'b0;
        unique case (state)
            FA_IDLE: begin
                if (pick_vld) begin
                    accept    = 1'b1;
                    state_nxt = FA_ISSUE;
                end
            end
            FA_ISSUE: begin
                if (!flash.waitrequest) begin
                    state_nxt = FA_DATA;
                end
            end
            FA_DATA: begin
                if (flash.readdatavalid && (beats_left == ONE_BEAT)) begin
                    last_beat = 1'b1;
                    state_nxt = FA_IDLE;
                end
            end
            default: state_nxt = FA_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= FA_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // A zero burstcount is a single beat; normalise once so the flash never sees 0.
    assign sel_burst = pick ? m1.burstcount : m0.burstcount;

    always_ff @(posedge clock) begin
        if (reset) begin
            grant      <= 1'b0;
            last_grant <= 1'b1;
            addr_q     <= '0;
            burst_q    <= '0;
            beats_left <= '0;
        end else begin
            if (accept) begin
                grant   <= pick;
                addr_q  <= pick ? m1.addr : m0.addr;
                burst_q <= (sel_burst == '0) ? ONE_REQ : sel_burst;
            end
            if ((state == FA_ISSUE) && !flash.waitrequest) begin
                beats_left <= {1'b0, burst_q};
            end else if ((state == FA_DATA) && flash.readdatavalid) begin
                beats_left <= beats_left - ONE_BEAT;
            end
            if (last_beat) begin
                last_grant <= grant;
            end
        end
    end

    assign flash.read       = (state == FA_ISSUE);
    assign flash.addr       = addr_q;
    assign flash.burstcount = burst_q;

    assign m0.waitrequest = !(accept && !reset && !pick);
    assign m1.waitrequest = !(accept && !reset &&  pick);

    // Beats outside DATA have no owner and are dropped.
    assign beat_ok          = (state == FA_DATA) && flash.readdatavalid && !reset;
    assign m0.readdatavalid = beat_ok && !grant;
    assign m1.readdatavalid = beat_ok &&  grant;

    assign rd_dat      = flash.readdata;
    assign m0.readdata = rd_dat;
    assign m1.readdata = rd_dat;
endmodule
